// File: rtl/pr_shutdown_seq_ctrl.sv
// pr_shutdown_seq_ctrl
// Partial-reconfiguration shutdown sequencer. It requests shutdown from up to
// C_NUM_CHANNELS pr_shutdown_axis shims and waits for their acknowledges. It then
// decouples the reconfigurable module (RM) and grants the PR controller. After
// pr_done it pulses the RM reset, releases the shims and returns to idle.
//
// Optional feature macro: PR_SHUTDOWN_SEQ_ORDERED_EN
//   defined   : channels are requested one at a time, lowest index first.
//               They are released in reverse order.
//   undefined : all masked channels are requested and released together.
//
// Handshake: shutdown_req/shutdown_ack is a four-phase level handshake per channel.
// 1. req rises.
// 2. The shim raises ack once drained.
// 3. req falls.
// 4. The shim drops ack.
// A channel is only released when its ack has fallen. pr_req/pr_ack follows the
// same four-phase rule towards the PR controller.
// pr_done is a qualifier that is sampled only while pr_ack is high.
// All outputs come straight from flops.
module pr_shutdown_seq_ctrl #(
  parameter int C_NUM_CHANNELS   = 4,
  parameter int C_TIMEOUT_CYCLES = 65535,
  parameter int C_RESET_CYCLES   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_NUM_CHANNELS-1:0] ch_mask,
  input  logic                      pr_req,
  output logic                      pr_ack,
  input  logic                      pr_done,
  output logic [C_NUM_CHANNELS-1:0] shutdown_req,
  input  logic [C_NUM_CHANNELS-1:0] shutdown_ack,
  output logic                      decouple,
  output logic                      rm_reset,
  output logic                      busy,
  output logic                      timeout,
  output logic [2:0]                state_dbg
);

  localparam int N  = C_NUM_CHANNELS;
  localparam int CW = (C_TIMEOUT_CYCLES > 0) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
  localparam int RW = $clog2(C_RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRAIN     = 3'd1,
    S_DECOUPLED = 3'd2,
    S_RESET_RM  = 3'd3,
    S_RELEASE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [N-1:0]   req_q, req_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0]  rcnt_q, rcnt_d;
  logic           timeout_q, timeout_d;
  logic           pr_ack_q, decouple_q, rm_reset_q, busy_q;

  logic           all_ack;
  logic           none_ack;
  logic           tmo_hit;
  logic           release_done;
  logic [N-1:0]   first_req;
  logic [N-1:0]   release_first;

`ifdef PR_SHUTDOWN_SEQ_ORDERED_EN
  logic [N-1:0]   pend;
  logic [N-1:0]   high_req;
  logic           step_ok;
  logic           rel_clear;

  // Isolate the lowest set bit of a channel vector.
  function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = N'(1) << i;
    end
    return r;
  endfunction
`endif

  // Masked acknowledge summaries. Unmasked ack bits are gated off before reduction.
  assign all_ack  = &(shutdown_ack | ~mask_q);
  assign none_ack = ~|(shutdown_ack & mask_q);

  // Saturating counter increment and timeout detection. A zero timeout disables it.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign tmo_hit = (C_TIMEOUT_CYCLES != 0) && (cnt_inc >= CW'(C_TIMEOUT_CYCLES));

  // The release is complete once every request is down and every masked ack has followed.
  assign release_done = (req_q == '0) && none_ack;

`ifdef PR_SHUTDOWN_SEQ_ORDERED_EN
  // Ordered helpers: channels still to request, and the most recently raised request.
  always_comb begin
    high_req = '0;
    for (int i = 0; i < N; i++) begin
      if (req_q[i]) high_req = N'(1) << i;
    end
  end

  assign pend          = mask_q & ~req_q;
  assign step_ok       = (&(shutdown_ack | ~req_q)) && (pend != '0);
  assign rel_clear     = ~|(shutdown_ack & mask_q & ~req_q);
  assign first_req     = lowest_bit(ch_mask);
  assign release_first = req_q & ~high_req;
`else
  assign first_req     = ch_mask;
  assign release_first = '0;
`endif

  // Next-state logic for the sequencer, mask, request vector and counters.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (pr_req) begin
          state_d   = S_DRAIN;
          mask_d    = ch_mask;
          req_d     = first_req;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (all_ack) begin
          state_d = S_DECOUPLED;
`ifdef PR_SHUTDOWN_SEQ_ORDERED_EN
        end else if (step_ok && pr_req) begin
          req_d = req_q | lowest_bit(pend);
          cnt_d = '0;
`endif
        end else if (tmo_hit) begin
          state_d   = S_DECOUPLED;
          timeout_d = 1'b1;
        end else if (!pr_req) begin
          state_d = S_RELEASE;
          req_d   = release_first;
          cnt_d   = '0;
        end
      end
      S_DECOUPLED: begin
        if (pr_done) begin
          state_d = S_RESET_RM;
          rcnt_d  = '0;
        end
      end
      S_RESET_RM: begin
        if (rcnt_q == RW'(C_RESET_CYCLES - 1)) begin
          state_d = S_RELEASE;
          req_d   = release_first;
          cnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_inc;
`ifdef PR_SHUTDOWN_SEQ_ORDERED_EN
        if ((req_q != '0) && rel_clear) begin
          req_d = release_first;
          cnt_d = '0;
        end
`endif
        if (tmo_hit && !release_done) timeout_d = 1'b1;
        if (!pr_req && (release_done || tmo_hit)) begin
          state_d = S_IDLE;
          req_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs. Reset aborts to idle with all outputs low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      req_q      <= '0;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      timeout_q  <= 1'b0;
      pr_ack_q   <= 1'b0;
      decouple_q <= 1'b0;
      rm_reset_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      timeout_q  <= timeout_d;
      pr_ack_q   <= (state_d == S_DECOUPLED) || (state_d == S_RESET_RM);
      decouple_q <= (state_d == S_DECOUPLED) || (state_d == S_RESET_RM);
      rm_reset_q <= (state_d == S_RESET_RM);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign shutdown_req = req_q;
  assign pr_ack       = pr_ack_q;
  assign decouple     = decouple_q;
  assign rm_reset     = rm_reset_q;
  assign busy         = busy_q;
  assign timeout      = timeout_q;
  assign state_dbg    = state_q;

endmodule
